// File: rtl/fetch_redirect_unit.sv
// Fetch stage and EX-stage redirect resolution: owns the PC, squashes the wrong-path slot on taken
// branch/jal/jalr. Define FETCH_MISALIGN_TRAP_EN to trap (freeze) on targets with bit 1 set.
module fetch_redirect_unit #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic [31:0]       instr_rdata,
    input  logic [1:0]        pcsel,
    input  logic              zcomp,
    input  logic              alu_zero,
    input  logic [31:0]       rs1_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    output logic [31:0]       instruction_EX,
    output logic [31:0]       pc_EX,
    output logic [31:0]       pc_plus4_EX,
    output logic              stall_EX,
    output logic              redirect,
    output logic              misalign_err
);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic        stall_ex_q, stall_ex_d;
    logic        trap_q, trap_d;

    logic [31:0] b_imm, j_imm, i_imm;
    logic [31:0] target;
    logic        taken;

    assign instruction_EX = stall_ex_q ? NOP_INSTR : instr_rdata;
    assign pc_EX          = pc_ex_q;
    assign pc_plus4_EX    = pc_ex_q + 32'd4;
    assign stall_EX       = stall_ex_q;
    assign imem_addr      = pc_f_q[ADDR_W+1:2];
    assign misalign_err   = trap_q;

    // A trapped unit stops reading so the ROM output stays put alongside the frozen PCs.
    assign imem_en = ~halt & ~trap_q;

    assign b_imm = {{19{instruction_EX[31]}}, instruction_EX[31], instruction_EX[7],
                    instruction_EX[30:25], instruction_EX[11:8], 1'b0};
    assign j_imm = {{11{instruction_EX[31]}}, instruction_EX[31], instruction_EX[19:12],
                    instruction_EX[20], instruction_EX[30:21], 1'b0};
    assign i_imm = {{20{instruction_EX[31]}}, instruction_EX[31:20]};

    always_comb begin
        taken = 1'b0;
        unique case (pcsel)
            2'b00: taken = 1'b0;
            2'b01: taken = (alu_zero == zcomp);
            2'b10: taken = 1'b1;
            2'b11: taken = 1'b1;
        endcase
        // A bubble in EX carries no real control flow, so it can never redirect.
        taken = taken & ~stall_ex_q & ~halt;
    end

    assign redirect = taken;

    always_comb begin
        target = pc_ex_q + 32'd4;
        unique case (pcsel)
            2'b00: target = pc_ex_q + 32'd4;
            2'b01: target = pc_ex_q + b_imm;
            2'b10: target = pc_ex_q + j_imm;
            2'b11: target = (rs1_data + i_imm) & ~32'h1;
        endcase
    end

    always_comb begin
        pc_f_d     = pc_f_q;
        pc_ex_d    = pc_ex_q;
        stall_ex_d = stall_ex_q;
        trap_d     = trap_q;
        if (halt || trap_q) begin
            // hold everything
        end else if (taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target[1]) begin
                trap_d     = 1'b1;
                stall_ex_d = 1'b1;
            end else begin
                pc_f_d     = target & ~32'h3;
                pc_ex_d    = pc_f_q;
                stall_ex_d = 1'b1;
            end
`else
            pc_f_d     = target & ~32'h3;
            pc_ex_d    = pc_f_q;
            stall_ex_d = 1'b1;
`endif
        end else begin
            pc_f_d     = pc_f_q + 32'd4;
            pc_ex_d    = pc_f_q;
            stall_ex_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_f_q     <= RESET_PC;
            pc_ex_q    <= 32'h0000_0000;
            stall_ex_q <= 1'b1;
            trap_q     <= 1'b0;
        end else begin
            pc_f_q     <= pc_f_d;
            pc_ex_q    <= pc_ex_d;
            stall_ex_q <= stall_ex_d;
            trap_q     <= trap_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: synchronous ROM model plus a scoreboard of expected
// EX-slot contents, with test-driven decoder/ALU inputs.
module tb_fetch_redirect_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] instr_rdata;
    logic [1:0]  pcsel = 2'b00;
    logic        zcomp = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs1_data = 32'h0;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [31:0] instruction_EX;
    logic [31:0] pc_EX;
    logic [31:0] pc_plus4_EX;
    logic        stall_EX;
    logic        redirect;
    logic        misalign_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        stall;
    } ex_t;

    ex_t         exp_q[$];
    ex_t         got;
    logic [31:0] rom [0:255];
    logic [31:0] cur_pc;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_redirect_unit #(
        .ADDR_W   (8),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt          (halt),
        .instr_rdata   (instr_rdata),
        .pcsel         (pcsel),
        .zcomp         (zcomp),
        .alu_zero      (alu_zero),
        .rs1_data      (rs1_data),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .instruction_EX(instruction_EX),
        .pc_EX         (pc_EX),
        .pc_plus4_EX   (pc_plus4_EX),
        .stall_EX      (stall_EX),
        .redirect      (redirect),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) instr_rdata <= rom[imem_addr];
    end

    function automatic ex_t fetched(input logic [31:0] pc);
        fetched = '{pc, rom[pc[9:2]], 1'b0};
    endfunction

    function automatic ex_t squashed(input logic [31:0] pc);
        squashed = '{pc, NOP, 1'b1};
    endfunction

    task automatic step(input ex_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
    endtask

    task automatic run_seq(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            cur_pc = cur_pc + 32'd4;
            step(fetched(cur_pc));
            vectors++;
            if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
                miscompares++;
                $display("FAIL %s: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                         name, pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (pc_EX !== 32'h0 || stall_EX !== 1'b1 || instruction_EX !== NOP) begin
            miscompares++;
            $display("FAIL reset_ex: pc=%h stall=%b instr=%h, expected 0/1/%h",
                     pc_EX, stall_EX, instruction_EX, NOP);
        end
        vectors++;
        if (redirect !== 1'b0 || misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: redirect=%b misalign=%b, expected 0/0", redirect,
                     misalign_err);
        end
        vectors++;
        if (imem_addr !== 8'h00 || imem_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_fetch: addr=%h en=%b, expected 00/1", imem_addr, imem_en);
        end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        cur_pc = 32'h0;
        step(fetched(32'h0));
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
            miscompares++;
            $display("FAIL first_fetch: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                     pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
        end
        run_seq(1, "second_fetch");
        vectors++;
        if (pc_plus4_EX !== 32'h8) begin
            miscompares++;
            $display("FAIL link_value: pc_plus4=%h, expected 00000008", pc_plus4_EX);
        end
    endtask

    task automatic test_branch_taken();
        run_seq(3, "seq_to_0x10");
        pcsel = 2'b01; zcomp = 1'b1; alu_zero = 1'b1;
        #1;
        vectors++;
        if (redirect !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_redirect: redirect=%b, expected 1", redirect);
        end
        step(squashed(32'h14));
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
            miscompares++;
            $display("FAIL beq_squash: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                     pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
        end
        // Branch inputs still asserted during the bubble must be ignored.
        vectors++;
        if (redirect !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_no_double: redirect=%b, expected 0", redirect);
        end
        cur_pc = 32'h18;
        step(fetched(cur_pc));
        pcsel = 2'b00;
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
            miscompares++;
            $display("FAIL beq_target: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                     pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
        end
    endtask

    task automatic test_branch_not_taken();
        run_seq(2, "seq_to_0x20");
        pcsel = 2'b01; zcomp = 1'b0; alu_zero = 1'b1;
        #1;
        vectors++;
        if (redirect !== 1'b0) begin
            miscompares++;
            $display("FAIL blt_redirect: redirect=%b, expected 0", redirect);
        end
        run_seq(1, "blt_fallthrough");
        pcsel = 2'b00;
    endtask

    task automatic test_halt_jal();
        run_seq(3, "seq_to_0x30");
        pcsel = 2'b10;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (redirect !== 1'b0 || imem_en !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_gate: cycle %0d redirect=%b en=%b, expected 0/0", i, redirect,
                         imem_en);
            end
            step(fetched(32'h30));
            vectors++;
            if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
                miscompares++;
                $display("FAIL halt_hold: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                         pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
            end
        end
        halt = 1'b0;
        #1;
        vectors++;
        if (redirect !== 1'b1) begin
            miscompares++;
            $display("FAIL jal_redirect: redirect=%b, expected 1", redirect);
        end
        step(squashed(32'h34));
        pcsel = 2'b00;
        cur_pc = 32'h0;
        step(fetched(cur_pc));
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
            miscompares++;
            $display("FAIL jal_target: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                     pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
        end
    endtask

    task automatic test_reset_mid_redirect();
        run_seq(4, "seq_to_0x10b");
        pcsel = 2'b01; zcomp = 1'b1; alu_zero = 1'b1;
        step(squashed(32'h14));
        pcsel = 2'b00;
        rst_n = 1'b0;
        step(squashed(32'h0));
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall ||
            imem_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: pc=%h stall=%b addr=%h, expected pc=%h stall=%b addr=00",
                     pc_EX, stall_EX, imem_addr, got.pc, got.stall);
        end
        rst_n = 1'b1;
        cur_pc = 32'h0;
        step(fetched(cur_pc));
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall) begin
            miscompares++;
            $display("FAIL reset_restart: pc=%h instr=%h stall=%b, expected pc=%h instr=%h stall=%b",
                     pc_EX, instruction_EX, stall_EX, got.pc, got.instr, got.stall);
        end
    endtask

    task automatic test_jalr();
        run_seq(9, "seq_to_0x24");
        pcsel = 2'b11;
        rs1_data = 32'h103;
        #1;
        vectors++;
        if (redirect !== 1'b1) begin
            miscompares++;
            $display("FAIL jalr_redirect: redirect=%b, expected 1", redirect);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            step(squashed(32'h24));
            pcsel = 2'b00;
            vectors++;
            if (pc_EX !== got.pc || stall_EX !== got.stall || misalign_err !== 1'b1 ||
                imem_en !== 1'b0 || redirect !== 1'b0) begin
                miscompares++;
                $display("FAIL jalr_trap: pc=%h stall=%b err=%b en=%b, expected pc=%h 1/1/0",
                         pc_EX, stall_EX, misalign_err, imem_en, got.pc);
            end
        end
`else
        step(squashed(32'h28));
        pcsel = 2'b00;
        cur_pc = 32'h104;
        step(fetched(cur_pc));
        vectors++;
        if (pc_EX !== got.pc || instruction_EX !== got.instr || stall_EX !== got.stall ||
            misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL jalr_target: pc=%h instr=%h stall=%b err=%b, expected pc=%h instr=%h 0/0",
                     pc_EX, instruction_EX, stall_EX, misalign_err, got.pc, got.instr);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013 | (i << 20);
        rom[0]  = 32'h0050_0093;
        rom[1]  = 32'h00A0_0113;
        rom[4]  = 32'h0000_0463;   // beq x0,x0,+8
        rom[8]  = 32'h0000_4463;   // blt x0,x0,+8
        rom[9]  = 32'h0041_00E7;   // jalr x1,4(x2)
        rom[12] = 32'hFD1F_F06F;   // jal x0,-48
        test_reset();
        test_first_fetch();
        test_branch_taken();
        test_branch_not_taken();
        test_halt_jal();
        test_reset_mid_redirect();
        test_jalr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end

endmodule
